// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and Control_Unit:
// default widths, opcode constants and the sequencer state encoding.
package instr_sequencer_pkg;

  localparam int INSTR_W_DEF = 16;
  localparam int PC_W_DEF    = 8;
  localparam int BOFF_W_DEF  = 6;
  localparam int OP_W        = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_HALT    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_ISSUE   = 2'b10,
    ST_RESOLVE = 2'b11
  } seq_state_t;

endpackage

// File: rtl/instr_sequencer_next_pc_calc.sv
// Next-PC selection: jump target, taken branch (pc+1+signed offset) or pc+1.
// All arithmetic wraps modulo 2^PC_W.
module next_pc_calc #(
  parameter int PC_W   = 8,
  parameter int BOFF_W = 6
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] instr_lo,
  input  logic            jump,
  input  logic            branch,
  input  logic            alu_zero,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc_inc_s;
  logic [PC_W-1:0] boff_sext_s;

  // Priority select; jump overrides a simultaneous taken branch
  always_comb begin
    pc_inc_s    = pc + {{(PC_W-1){1'b0}}, 1'b1};
    boff_sext_s = {{(PC_W-BOFF_W){instr_lo[BOFF_W-1]}}, instr_lo[BOFF_W-1:0]};
    if (jump) begin
      next_pc = instr_lo;
    end else if (branch && alu_zero) begin
      next_pc = pc_inc_s + boff_sext_s;
    end else begin
      next_pc = pc_inc_s;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches from imem, issues the opcode to
// Control_Unit over valid/ready and resolves the next PC from jump/branch/zero.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int              INSTR_W = INSTR_W_DEF,
  parameter int              PC_W    = PC_W_DEF,
  parameter int              BOFF_W  = BOFF_W_DEF,
  parameter logic [OP_W-1:0] HALT_OP = OP_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [2:0]         control_opcode,
  output logic               op_valid,
  input  logic               op_ready,
  input  logic               jump,
  input  logic               branch,
  input  logic               alu_zero,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  seq_state_t         state_r, state_next_s;
  logic [PC_W-1:0]    pc_r, pc_inc_s, next_pc_s;
  logic [INSTR_W-1:0] instr_r;
  logic [OP_W-1:0]    control_opcode_r, fetch_op_s;
  logic               imem_req_r, op_valid_r, halted_r;
  logic               fetch_done_s, fetch_halt_s;
  logic               unused_instr_bits_s;

  next_pc_calc #(
    .PC_W   (PC_W),
    .BOFF_W (BOFF_W)
  ) u_next_pc_calc (
    .pc       (pc_r),
    .instr_lo (instr_r[PC_W-1:0]),
    .jump     (jump),
    .branch   (branch),
    .alu_zero (alu_zero),
    .next_pc  (next_pc_s)
  );

  assign unused_instr_bits_s = ^instr_r[INSTR_W-OP_W-1:PC_W];

  // Opcode field of the word arriving from imem and the sequential pc+1
  always_comb begin
    fetch_op_s = imem_rdata[INSTR_W-1 -: OP_W];
    pc_inc_s   = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  end

  // Next-state logic; a fetched HALT_OP bypasses ISSUE/RESOLVE entirely
  always_comb begin
    state_next_s = state_r;
    fetch_done_s = 1'b0;
    fetch_halt_s = 1'b0;
    case (state_r)
      ST_HALT: begin
        if (run) state_next_s = ST_FETCH;
        else     state_next_s = ST_HALT;
      end
      ST_FETCH: begin
        if (imem_valid) begin
          fetch_done_s = 1'b1;
          if (fetch_op_s == HALT_OP) begin
            fetch_halt_s = 1'b1;
            state_next_s = ST_HALT;
          end else begin
            state_next_s = ST_ISSUE;
          end
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_ISSUE: begin
        if (op_ready) state_next_s = ST_RESOLVE;
        else          state_next_s = ST_ISSUE;
      end
      ST_RESOLVE: begin
        if (run) state_next_s = ST_FETCH;
        else     state_next_s = ST_HALT;
      end
      default: state_next_s = ST_HALT;
    endcase
  end

  // State, PC, instruction and registered outputs (decoded from the next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_HALT;
      pc_r             <= {PC_W{1'b0}};
      instr_r          <= {INSTR_W{1'b0}};
      control_opcode_r <= OP_NOP;
      imem_req_r       <= 1'b0;
      op_valid_r       <= 1'b0;
      halted_r         <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      imem_req_r <= (state_next_s == ST_FETCH);
      op_valid_r <= (state_next_s == ST_ISSUE);
      halted_r   <= (state_next_s == ST_HALT);
      if (fetch_done_s) begin
        instr_r          <= imem_rdata;
        control_opcode_r <= fetch_op_s;
      end
      if (fetch_halt_s) begin
        pc_r <= pc_inc_s;
      end else if (state_r == ST_RESOLVE) begin
        pc_r <= next_pc_s;
      end
    end
  end

  assign imem_req       = imem_req_r;
  assign imem_addr      = pc_r;
  assign control_opcode = control_opcode_r;
  assign op_valid       = op_valid_r;
  assign pc             = pc_r;
  assign halted         = halted_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: directed corner cases then random
// instructions, checked against a behavioural next-PC reference model.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        op_ready = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        alu_zero = 1'b0;
  logic        imem_req, op_valid, halted;
  logic [7:0]  imem_addr, pc;
  logic [2:0]  control_opcode;

  int total = 0;
  int bad = 0;
  int model_pc = 0;
  logic [7:0] exp_addr_q[$];
  logic [2:0] exp_op_q[$];

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .control_opcode(control_opcode), .op_valid(op_valid), .op_ready(op_ready),
    .jump(jump), .branch(branch), .alu_zero(alu_zero),
    .pc(pc), .halted(halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: next PC from the instruction rules using plain integer arithmetic
  function automatic int ref_next_pc(input int cur, input logic [15:0] ins,
                                     input bit j, input bit b, input bit z);
    int off;
    if (j) return int'(ins[7:0]);
    if (b && z) begin
      off = int'(ins[5:0]);
      if (off >= 32) off -= 64;
      return ((cur + 1 + off) % 256 + 256) % 256;
    end
    return (cur + 1) % 256;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: serve the fetch, hold ISSUE, let RESOLVE update the PC
  task automatic do_instr(input logic [15:0] ins, input bit j, input bit b, input bit z,
                          input int fetch_dly, input int ready_dly, input bit drop_run);
    int n;
    int old_pc;
    logic [2:0] op;
    op = ins[15:13];
    n = 0;
    while (!imem_req && n < 20) begin step(); n++; end
    if (!imem_req) begin
      check("fetch_timeout", 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < fetch_dly; k++) begin
      op_ready = 1'($urandom_range(0, 1));
      step();
    end
    op_ready = 1'b0;
    imem_rdata = ins; imem_valid = 1'b1;
    jump = j; branch = b; alu_zero = z;
    old_pc = model_pc;
    if (op == 3'b111) begin
      run = 1'b0;
      model_pc = (model_pc + 1) % 256;
      exp_addr_q.push_back(8'(model_pc));
      step();
      imem_valid = 1'b0; imem_rdata = 16'($urandom);
      check("halt_halted", halted, 1'b1);
      check("halt_no_op_valid", op_valid, 1'b0);
      check("halt_pc", pc, model_pc);
      run = 1'b1;
      return;
    end
    exp_op_q.push_back(op);
    model_pc = ref_next_pc(model_pc, ins, j, b, z);
    exp_addr_q.push_back(8'(model_pc));
    step();
    imem_valid = 1'b0; imem_rdata = 16'($urandom);
    if (drop_run) run = 1'b0;
    check("issue_valid", op_valid, 1'b1);
    check("issue_opcode", control_opcode, op);
    for (int k = 0; k < ready_dly; k++) begin
      imem_valid = 1'($urandom_range(0, 1));
      step();
      check("stall_valid", op_valid, 1'b1);
      check("stall_opcode", control_opcode, op);
      check("stall_pc", pc, old_pc);
    end
    imem_valid = 1'b0;
    op_ready = 1'b1;
    step();
    op_ready = 1'b0;
    check("resolve_no_valid", op_valid, 1'b0);
    step();
    check("resolved_pc", pc, model_pc);
    if (drop_run) begin
      check("run_drop_halted", halted, 1'b1);
      check("run_drop_no_req", imem_req, 1'b0);
      run = 1'b1;
    end else begin
      check("refetch_req", imem_req, 1'b1);
    end
  endtask

  // Monitor: pops expected fetch addresses and opcodes on each handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_req && imem_valid) begin
        if (exp_addr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL fetch_unexpected: addr %0h with nothing expected", imem_addr);
        end else begin
          check("fetch_addr", imem_addr, exp_addr_q.pop_front());
        end
      end
      if (op_valid) begin
        if (exp_op_q.size() == 0) begin
          total++; bad++;
          $display("FAIL op_unexpected: opcode %0h valid with nothing expected", control_opcode);
        end else if (op_ready) begin
          check("op_accept", control_opcode, exp_op_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1;
    repeat (2) step();
    check("rst_halted", halted, 1'b1);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", op_valid, 1'b0);
    check("rst_pc", pc, 8'h00);
    check("rst_opcode", control_opcode, 3'b000);
    rst_n = 1'b1;
    step();
    check("idle_stays_halted", halted, 1'b1);
    exp_addr_q.push_back(8'h00);
    model_pc = 0;
    run = 1'b1;

    do_instr(16'h2000, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    check("t2_pc", pc, 8'h01);
    do_instr(16'h8005, 1'b1, 1'b0, 1'b0, 0, 4, 1'b0);
    do_instr(16'h8042, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0);
    check("t4_jump_wins", pc, 8'h42);
    do_instr(16'h8003, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    do_instr(16'h203C, 1'b0, 1'b1, 1'b1, 2, 1, 1'b0);
    check("t5_neg_branch", pc, 8'h00);
    do_instr(16'h8003, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    do_instr(16'h203C, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    check("t5_not_taken", pc, 8'h04);
    do_instr(16'h80FF, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    do_instr(16'h2000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("t5_wrap", pc, 8'h00);
    do_instr(16'hE000, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check("t6_halt_pc", pc, 8'h01);
    do_instr(16'h4000, 1'b0, 1'b0, 1'b0, 0, 2, 1'b1);
    check("t6_run_drop_pc", pc, 8'h02);

    for (int i = 0; i < 160; i++) begin
      do_instr(16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3),
               ($urandom_range(0, 7) == 0));
    end

    for (int n = 0; n < 20 && !imem_req; n++) step();
    check("pre_reset_req", imem_req, 1'b1);
    check("pre_reset_addr", imem_addr, model_pc);
    rst_n = 1'b0;
    #1;
    check("async_req", imem_req, 1'b0);
    check("async_valid", op_valid, 1'b0);
    check("async_pc", pc, 8'h00);
    check("async_halted", halted, 1'b1);
    exp_addr_q.delete();
    exp_op_q.delete();
    run = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    model_pc = 0;
    exp_addr_q.push_back(8'h00);
    run = 1'b1;
    do_instr(16'h2000, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
    check("post_reset_pc", pc, 8'h01);
    check("addr_q_drained", exp_addr_q.size(), 1);
    check("op_q_drained", exp_op_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
